// File: rtl/life_sequencer.sv
// -----------------------------------------------------------------------------
// life_sequencer
//
// Generation scheduler for the 8x8 Game-of-Life board datapath. It owns the
// 64-bit board register, loads it from a seed, and commits the externally
// computed next generation on a prescaled tick (RUN) or on demand (PAUSE +
// step). It stops in HALT on extinction, a still life, or the generation limit.
//
// Parameters:
//   TICK_DIV  clock cycles per generation while running (1..65535)
//   MAX_GEN   generation limit that forces HALT; 0 disables the limit
//   GEN_W     width of gen_count
//
// Ports:
//   clk         in   system clock, rising-edge
//   reset       in   asynchronous active-high reset
//   load_seed   in   level: copy seed into board, clear gen_count, go IDLE
//   start       in   level: enter or resume RUN
//   pause       in   level: RUN -> PAUSE
//   step        in   pulse: one commit while paused
//   seed        in   64-bit initial pattern
//   next_board  in   64-bit next generation from the combinational datapath
//   board       out  current board register
//   gen_count   out  generations committed since the last load
//   state       out  IDLE=0, RUN=1, PAUSE=2, HALT=3
//   commit      out  one-cycle pulse following each board update
//   done        out  high exactly while in HALT
// -----------------------------------------------------------------------------
module life_sequencer #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned MAX_GEN  = 255,
  parameter int unsigned GEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_seed,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic [63:0]      seed,
  input  logic [63:0]      next_board,
  output logic [63:0]      board,
  output logic [GEN_W-1:0] gen_count,
  output logic [1:0]       state,
  output logic             commit,
  output logic             done
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);

  // Elaboration-time parameter sanity.
  if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
    $error("life_sequencer: TICK_DIV out of range");
  end
  if (GEN_W < 1) begin : g_bad_gen_w
    $error("life_sequencer: GEN_W must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StHalt  = 2'd3
  } state_e;

  // State registers.
  state_e            r_state;
  logic [63:0]       r_board;
  logic [GEN_W-1:0]  r_gen;
  logic [CntW-1:0]   r_cnt;
  logic              r_commit;
  logic              r_done;

  // Next-state values.
  state_e            w_state_d;
  logic [63:0]       w_board_d;
  logic [GEN_W-1:0]  w_gen_d;
  logic [CntW-1:0]   w_cnt_d;
  logic              w_do_commit;

  // Halt conditions, all judged against pre-commit values.
  logic              w_extinct;
  logic              w_still;
  logic              w_limit;
  logic              w_halt;
  logic [GEN_W-1:0]  w_gen_next;
  logic              w_resume;

  assign w_extinct = (next_board == 64'd0);
  assign w_still   = (next_board == r_board);
  assign w_limit   = (MAX_GEN != 0) && ((32'(r_gen) + 32'd1) == 32'(MAX_GEN));
  assign w_halt    = w_extinct || w_still || w_limit;

  // With a limit in force the count must never wrap; saturate defensively in
  // case MAX_GEN exceeds the counter range. Without a limit it wraps freely.
  assign w_gen_next = ((MAX_GEN != 0) && (&r_gen)) ? r_gen : r_gen + GEN_W'(1);

  // pause has priority over start whenever both are high.
  assign w_resume = start && !pause;

  always_comb begin
    w_state_d   = r_state;
    w_board_d   = r_board;
    w_gen_d     = r_gen;
    w_cnt_d     = r_cnt;
    w_do_commit = 1'b0;

    if (load_seed) begin
      w_state_d = StIdle;
      w_board_d = seed;
      w_gen_d   = '0;
      w_cnt_d   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            w_state_d = StRun;
            w_cnt_d   = '0;
          end
        end

        StRun: begin
          if (r_cnt == TickLast) begin
            w_do_commit = 1'b1;
            w_cnt_d     = '0;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
          if (pause) begin
            w_state_d = StPause;
          end
        end

        StPause: begin
          // A plain step keeps the tick counter parked so that a later resume
          // continues the interrupted period; step+start restarts the period.
          if (step) begin
            w_do_commit = 1'b1;
            if (w_resume) begin
              w_state_d = StRun;
              w_cnt_d   = '0;
            end
          end else if (w_resume) begin
            w_state_d = StRun;
          end
        end

        StHalt: begin
          // Frozen until load_seed or reset.
        end

        default: begin
          w_state_d = StIdle;
        end
      endcase

      if (w_do_commit) begin
        w_board_d = next_board;
        w_gen_d   = w_gen_next;
        // Halt outranks any pause/run transition decided above.
        if (w_halt) begin
          w_state_d = StHalt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_board  <= '0;
      r_gen    <= '0;
      r_cnt    <= '0;
      r_commit <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_board  <= w_board_d;
      r_gen    <= w_gen_d;
      r_cnt    <= w_cnt_d;
      r_commit <= w_do_commit;
      r_done   <= (w_state_d == StHalt);
    end
  end

  assign board     = r_board;
  assign gen_count = r_gen;
  assign state     = r_state;
  assign commit    = r_commit;
  assign done      = r_done;

endmodule

// File: tb/tb_life_sequencer.sv
module tb_life_sequencer;

  localparam logic [63:0] BlinkA = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BlinkB = 64'h0000_0008_0808_0000;
  localparam logic [63:0] Block  = 64'h0000_0018_1800_0000;
  localparam logic [63:0] Misc   = 64'h0123_4567_89AB_CDEF;

  logic        clk;
  logic        reset;
  logic        load_seed, start, pause, step;
  logic [63:0] seed;
  logic [63:0] nb1, nb2;
  logic [1:0]  mode;  // 0 blinker, 1 still (next=board), 2 extinct (next=0)

  logic [63:0] board1;
  logic [7:0]  gen1;
  logic [1:0]  st1;
  logic        commit1, done1;

  logic        l_load, l_start;
  logic [63:0] board2;
  logic [7:0]  gen2;
  logic [1:0]  st2;
  logic        commit2, done2;

  int cyc;
  int n_checks;
  int n_fail;

  typedef struct {
    int          cyc;
    logic [63:0] board;
    logic [7:0]  gen;
    logic [1:0]  st;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  life_sequencer #(.TICK_DIV(4), .MAX_GEN(255), .GEN_W(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load_seed  (load_seed),
    .start      (start),
    .pause      (pause),
    .step       (step),
    .seed       (seed),
    .next_board (nb1),
    .board      (board1),
    .gen_count  (gen1),
    .state      (st1),
    .commit     (commit1),
    .done       (done1)
  );

  life_sequencer #(.TICK_DIV(1), .MAX_GEN(3), .GEN_W(8)) u_dut_lim (
    .clk        (clk),
    .reset      (reset),
    .load_seed  (l_load),
    .start      (l_start),
    .pause      (1'b0),
    .step       (1'b0),
    .seed       (seed),
    .next_board (nb2),
    .board      (board2),
    .gen_count  (gen2),
    .state      (st2),
    .commit     (commit2),
    .done       (done2)
  );

  // Datapath stand-in.
  always_comb begin
    nb1 = (board1 == BlinkA) ? BlinkB : BlinkA;
    if (mode == 2'd1) nb1 = board1;
    else if (mode == 2'd2) nb1 = 64'd0;
    nb2 = (board2 == BlinkA) ? BlinkB : BlinkA;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push1(int c, logic [63:0] b, int g, int s);
    exp_t e;
    e.cyc = c; e.board = b; e.gen = 8'(g); e.st = 2'(s);
    q1.push_back(e);
  endfunction

  function automatic void push2(int c, logic [63:0] b, int g, int s);
    exp_t e;
    e.cyc = c; e.board = b; e.gen = 8'(g); e.st = 2'(s);
    q2.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitors: every commit pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!reset && commit1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL commit1_unexpected: commit at cyc=%0d board=%h gen=%0d, none required",
                 cyc, board1, gen1);
      end else begin
        e1 = q1.pop_front();
        if (cyc != e1.cyc || board1 !== e1.board || gen1 !== e1.gen || st1 !== e1.st ||
            done1 !== (e1.st == 2'd3)) begin
          n_fail++;
          $display("FAIL commit1: got cyc=%0d board=%h gen=%0d state=%0d done=%b, required cyc=%0d board=%h gen=%0d state=%0d",
                   cyc, board1, gen1, st1, done1, e1.cyc, e1.board, e1.gen, e1.st);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && commit2) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL commit2_unexpected: commit at cyc=%0d board=%h gen=%0d, none required",
                 cyc, board2, gen2);
      end else begin
        e2 = q2.pop_front();
        if (cyc != e2.cyc || board2 !== e2.board || gen2 !== e2.gen || st2 !== e2.st ||
            done2 !== (e2.st == 2'd3)) begin
          n_fail++;
          $display("FAIL commit2: got cyc=%0d board=%h gen=%0d state=%0d done=%b, required cyc=%0d board=%h gen=%0d state=%0d",
                   cyc, board2, gen2, st2, done2, e2.cyc, e2.board, e2.gen, e2.st);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_load(input logic [63:0] s);
    seed = s;
    load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int c;
  int d;

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    reset = 1'b1; load_seed = 0; start = 0; pause = 0; step = 0;
    l_load = 0; l_start = 0; seed = '0; mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_board", board1, 64'd0);
    chk("reset_gen", 64'(gen1), 64'd0);
    chk("reset_state", 64'(st1), 64'd0);
    chk("reset_commit_done", {62'd0, commit1, done1}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Load and run: blinker, TICK_DIV=4.
    mode = 2'd0;
    do_load(BlinkA);
    chk("load_board", board1, BlinkA);
    chk("load_state", 64'(st1), 64'd0);
    start = 1'b1; c = cyc;
    push1(c + 5, BlinkB, 1, 1);
    push1(c + 9, BlinkA, 2, 1);
    push1(c + 13, BlinkB, 3, 1);
    @(negedge clk); start = 1'b0;
    chk("run_state", 64'(st1), 64'd1);

    // Pause when the counter reaches 2 (edge c+15).
    wait_cyc(c + 14);
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    chk("pause_state", 64'(st1), 64'd2);
    repeat (10) @(negedge clk);
    chk("pause_hold_gen", 64'(gen1), 64'd3);
    chk("pause_hold_done", 64'(done1), 64'd0);

    step = 1'b1; d = cyc; push1(d + 1, BlinkA, 4, 2);
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    step = 1'b1; d = cyc; push1(d + 1, BlinkB, 5, 2);
    @(negedge clk); step = 1'b0;
    repeat (3) @(negedge clk);
    chk("step_gen", 64'(gen1), 64'd5);
    chk("step_state", 64'(st1), 64'd2);

    // Resume: counter continues from 2, so commit two edges after the resume edge.
    start = 1'b1; d = cyc; push1(d + 3, BlinkA, 6, 1);
    @(negedge clk); start = 1'b0;
    wait_cyc(d + 3);

    // load_seed with start while running.
    seed = Misc; load_seed = 1'b1; start = 1'b1;
    @(negedge clk); load_seed = 1'b0; start = 1'b0;
    chk("loadprio_state", 64'(st1), 64'd0);
    chk("loadprio_board", board1, Misc);
    chk("loadprio_gen", 64'(gen1), 64'd0);
    repeat (6) @(negedge clk);
    chk("loadprio_idle_hold", 64'(st1), 64'd0);

    // Still life.
    mode = 2'd1;
    do_load(Block);
    start = 1'b1; c = cyc; push1(c + 5, Block, 1, 3);
    @(negedge clk); start = 1'b0;
    wait_cyc(c + 6);
    chk("still_done", 64'(done1), 64'd1);
    start = 1'b1; step = 1'b1; pause = 1'b1;
    @(negedge clk); start = 1'b0; step = 1'b0; pause = 1'b0;
    repeat (6) @(negedge clk);
    chk("still_frozen_board", board1, Block);
    chk("still_frozen_gen", 64'(gen1), 64'd1);
    chk("still_frozen_state", 64'(st1), 64'd3);

    // Extinction.
    mode = 2'd2;
    do_load(64'd1);
    chk("extinct_load_exits_halt", {62'd0, st1}, 64'd0);
    start = 1'b1; c = cyc; push1(c + 5, 64'd0, 1, 3);
    @(negedge clk); start = 1'b0;
    wait_cyc(c + 7);
    chk("extinct_state", 64'(st1), 64'd3);

    // Asynchronous reset mid-RUN.
    mode = 2'd0;
    do_load(BlinkA);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("areset_board", board1, 64'd0);
    chk("areset_gen_state", {54'd0, gen1, st1}, 64'd0);
    chk("areset_commit_done", {62'd0, commit1, done1}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("areset_idle", 64'(st1), 64'd0);

    // Generation limit: MAX_GEN=3, TICK_DIV=1.
    seed = BlinkA; l_load = 1'b1;
    @(negedge clk); l_load = 1'b0;
    l_start = 1'b1; c = cyc;
    push2(c + 2, BlinkB, 1, 1);
    push2(c + 3, BlinkA, 2, 1);
    push2(c + 4, BlinkB, 3, 3);
    @(negedge clk); l_start = 1'b0;
    wait_cyc(c + 10);
    chk("limit_gen", 64'(gen2), 64'd3);
    chk("limit_state", 64'(st2), 64'd3);
    chk("limit_done", 64'(done2), 64'd1);

    // All scheduled commits must have been observed.
    for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
